// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter (SLL/SRA/ROR/SRL), one power-of-two shift step per stage,
// valid/ready on both sides with a global stall; result, valid and zero flag are registered.
module shift_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] Shift_In,
  input  logic [SHW-1:0]   Shift_Val,
  input  logic [1:0]       Mode,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Shift_Out,
  output logic             Zero
);
  logic [SHW-1:0]   vld_q, vld_d;
  logic [WIDTH-1:0] dat_q [SHW];
  logic [WIDTH-1:0] dat_d [SHW];
  logic [SHW-1:0]   amt_q [SHW];
  logic [SHW-1:0]   amt_d [SHW];
  logic [1:0]       mode_q [SHW];
  logic [1:0]       mode_d [SHW];
  logic             out_vld_q, out_vld_d, zero_q, zero_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             stall;

  function automatic logic [WIDTH-1:0] shf(input logic [WIDTH-1:0] d, input logic [1:0] m, input int s);
    logic signed [WIDTH-1:0] sd;
    sd = d;
    if (m == 2'b00) return d << s;
    if (m == 2'b01) return sd >>> s;
    if (m == 2'b10) return (d >> s) | (d << (WIDTH - s));
    return d >> s;
  endfunction

  assign stall     = out_vld_q & ~Out_Ready;
  assign In_Ready  = ~stall;
  assign Out_Valid = out_vld_q;
  assign Shift_Out = out_q;
  assign Zero      = zero_q;

  // register k holds the operand after shift steps 0..k-1; the last step feeds the output register
  always_comb begin
    vld_d[0]  = In_Valid;
    dat_d[0]  = Shift_In;
    amt_d[0]  = Shift_Val;
    mode_d[0] = Mode;
    for (int k = 1; k < SHW; k++) begin
      vld_d[k]  = vld_q[k-1];
      dat_d[k]  = amt_q[k-1][k-1] ? shf(dat_q[k-1], mode_q[k-1], 1 << (k - 1)) : dat_q[k-1];
      amt_d[k]  = amt_q[k-1];
      mode_d[k] = mode_q[k-1];
    end
    out_vld_d = vld_q[SHW-1];
    out_d     = amt_q[SHW-1][SHW-1] ? shf(dat_q[SHW-1], mode_q[SHW-1], 1 << (SHW - 1)) : dat_q[SHW-1];
    zero_d    = out_d == '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      dat_q     <= '{default: '0};
      amt_q     <= '{default: '0};
      mode_q    <= '{default: '0};
      out_vld_q <= 1'b0;
      out_q     <= '0;
      zero_q    <= 1'b0;
    end else if (!stall) begin
      vld_q     <= vld_d;
      dat_q     <= dat_d;
      amt_q     <= amt_d;
      mode_q    <= mode_d;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
      zero_q    <= zero_d;
    end
  end
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed vector table, latency/backpressure/reset sequences and a random
// scoreboard run checked against a whole-amount arithmetic reference model.
module tb_shift_pipe;
  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         In_Valid = 1'b0, In_Ready, Out_Valid, Out_Ready = 1'b1, Zero;
  logic [W-1:0] Shift_In = '0, Shift_Out;
  logic [S-1:0] Shift_Val = '0;
  logic [1:0]   Mode = '0;

  int errors = 0, checks = 0, npop = 0;
  logic acc;
  logic [W-1:0] q[$];

  shift_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Shift_In(Shift_In), .Shift_Val(Shift_Val), .Mode(Mode),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Shift_Out(Shift_Out), .Zero(Zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   m;
    logic [S-1:0] n;
    logic [W-1:0] d;
    logic [W-1:0] e;
    logic         z;
  } vec_t;

  function automatic logic [W-1:0] model(logic [W-1:0] d, logic [S-1:0] n, logic [1:0] m);
    logic [2*W-1:0] dd;
    logic signed [W-1:0] sd;
    dd = {d, d};
    sd = d;
    if (m == 2'b00) return d << n;
    if (m == 2'b01) return sd >>> n;
    if (m == 2'b10) return W'(dd >> n);
    return d >> n;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    logic [W-1:0] e;
    #1;
    acc = In_Valid && In_Ready;
    if (acc) q.push_back(model(Shift_In, Shift_Val, Mode));
    if (Out_Valid && Out_Ready) begin
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = q.pop_front();
        npop++;
        chk("sb_data", Shift_Out, e);
        chk("sb_zero", Zero, e == '0);
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_op();
    Shift_In  = W'($urandom);
    Shift_Val = S'($urandom);
    Mode      = 2'($urandom);
  endtask

  task automatic send_one(vec_t v, string nm);
    int lat;
    Mode = v.m; Shift_Val = v.n; Shift_In = v.d; In_Valid = 1'b1; Out_Ready = 1'b1;
    @(negedge clk);
    In_Valid = 1'b0;
    lat = 0;
    while (!Out_Valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, lat, 4);
    chk({nm, "_data"}, Shift_Out, v.e);
    chk({nm, "_zero"}, Zero, v.z);
  endtask

  initial begin
    vec_t tbl[12];
    logic [W-1:0] so;
    logic zo;
    int nacc, bound;
    tbl[0]  = '{2'b10, 4'd4,  16'h1234, 16'h4123, 1'b0};
    tbl[1]  = '{2'b01, 4'd15, 16'h8000, 16'hFFFF, 1'b0};
    tbl[2]  = '{2'b11, 4'd15, 16'h8000, 16'h0001, 1'b0};
    tbl[3]  = '{2'b00, 4'd15, 16'h0001, 16'h8000, 1'b0};
    tbl[4]  = '{2'b00, 4'd1,  16'h8000, 16'h0000, 1'b1};
    tbl[5]  = '{2'b01, 4'd15, 16'h7FFF, 16'h0000, 1'b1};
    tbl[6]  = '{2'b01, 4'd4,  16'hF0F0, 16'hFF0F, 1'b0};
    tbl[7]  = '{2'b10, 4'd1,  16'h0001, 16'h8000, 1'b0};
    tbl[8]  = '{2'b11, 4'd0,  16'hA5A5, 16'hA5A5, 1'b0};
    tbl[9]  = '{2'b00, 4'd0,  16'hA5A5, 16'hA5A5, 1'b0};
    tbl[10] = '{2'b01, 4'd0,  16'h8001, 16'h8001, 1'b0};
    tbl[11] = '{2'b10, 4'd0,  16'h1234, 16'h1234, 1'b0};

    #2;
    chk("rst_out_valid", Out_Valid, 0);
    chk("rst_shift_out", Shift_Out, 0);
    chk("rst_zero", Zero, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", In_Ready, 1);

    foreach (tbl[i]) send_one(tbl[i], $sformatf("vec%0d", i));
    @(negedge clk);

    // back-to-back stream: results on consecutive cycles in order
    q.delete(); npop = 0;
    for (int j = 0; j < 15; j++) begin
      In_Valid = j < 8;
      Mode = 2'(j % 4); Shift_Val = S'(j); Shift_In = W'($urandom);
      chk($sformatf("stream_valid%0d", j), Out_Valid, (j >= 5 && j <= 12));
      tick();
    end
    chk("stream_pops", npop, 8);

    // backpressure: fill, then hold Out_Ready low and watch outputs freeze
    In_Valid = 1'b0; Out_Ready = 1'b1;
    repeat (6) tick();
    q.delete(); npop = 0;
    Out_Ready = 1'b0; In_Valid = 1'b1; rand_op();
    repeat (8) begin
      tick();
      if (acc) rand_op();
    end
    so = Shift_Out; zo = Zero;
    for (int j = 0; j < 5; j++) begin
      chk("bp_in_ready", In_Ready, 0);
      chk("bp_out_valid", Out_Valid, 1);
      chk("bp_shift_out", Shift_Out, so);
      chk("bp_zero", Zero, zo);
      tick();
    end
    In_Valid = 1'b0; Out_Ready = 1'b1;
    repeat (10) tick();
    chk("bp_pops", npop, 5);
    chk("bp_empty", q.size(), 0);

    // asynchronous reset mid-stream discards in-flight operands
    In_Valid = 1'b1;
    repeat (3) begin rand_op(); tick(); end
    In_Valid = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", Out_Valid, 0);
    chk("mid_rst_data", Shift_Out, 0);
    chk("mid_rst_zero", Zero, 0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("post_rst_no_valid", Out_Valid, 0);
      tick();
    end
    send_one(tbl[0], "post_rst");
    @(negedge clk);

    // random regression
    q.delete(); npop = 0; nacc = 0; bound = 0;
    In_Valid = 1'b1; rand_op();
    while (nacc < 10000 && bound < 60000) begin
      Out_Ready = ($urandom % 4) != 0;
      tick();
      bound++;
      if (acc) nacc++;
      if (acc || !In_Valid) begin
        In_Valid = (nacc < 10000) && ($urandom % 3 != 0);
        rand_op();
      end
    end
    In_Valid = 1'b0; Out_Ready = 1'b1;
    repeat (10) tick();
    chk("rand_accepted", nacc, 10000);
    chk("rand_pops", npop, 10000);
    chk("rand_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter for the ALU datapath.
- Supports four modes: SLL, SRL, SRA and ROR.
- Processes one operand per cycle with valid/ready handshakes on input and output.
- One log2(WIDTH) shift stage per pipeline register, so the critical path is a single mux level per cycle.

Parameters:
WIDTH, 16, data width in bits; must be a power of two, at least 4.
SHW, $clog2(WIDTH), shift-amount width and pipeline depth (derived; do not override).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
In_Valid  input  1  operand present on Shift_In/Shift_Val/Mode
In_Ready  output  1  block accepts operand this cycle
Shift_In  input  WIDTH  data to shift
Shift_Val  input  SHW  shift amount, 0..WIDTH-1
Mode  input  2  00 SLL, 01 SRA, 10 ROR, 11 SRL
Out_Valid  output  1  result present on Shift_Out/Zero
Out_Ready  input  1  consumer accepts result this cycle
Shift_Out  output  WIDTH  shifted result
Zero  output  1  Shift_Out == 0

Behaviour:
- Reset: clk and rst_n are the only clock and reset; reset is asynchronous, active-low.
  - While rst_n is low, all stage valid bits, data, amount and mode registers clear to 0.
  - Out_Valid=0, Shift_Out=0, Zero=0 (Zero is registered, not derived from the cleared data).
  - In_Ready=1 one cleared cycle after rst_n deasserts.
  - Asserting reset mid-operation discards all in-flight operands; none are output after release.
- Pipeline: SHW registered stages, numbered k=0..SHW-1.
  - Stage k shifts by 2^k when its carried Shift_Val[k]=1, otherwise passes data through.
  - Each stage register carries data, the remaining amount bits, Mode and a valid bit.
- Mode fill per stage:
  - SLL: shift left, fill low bits with 0.
  - SRL: shift right, fill high bits with 0.
  - SRA: shift right, fill with the stage's input MSB. This equals the original sign, because SRA preserves the MSB.
  - ROR: bits shifted out of the LSB re-enter at the MSB.
- Latency: operand accepted at edge N appears with Out_Valid=1 after edge N+SHW (4 cycles for WIDTH=16).
- Throughput: one operand per cycle when Out_Ready=1.
- Handshake:
  - Transfer in: In_Valid & In_Ready at a rising edge.
  - Transfer out: Out_Valid & Out_Ready at a rising edge.
  - stall = Out_Valid & ~Out_Ready; In_Ready = ~stall (combinational).
  - During stall no stage register updates. Shift_Out, Zero and Out_Valid hold stable, and no operand is accepted or lost.
  - Bubbles (stage valid=0) propagate normally. The global stall also freezes bubbles; bubble collapse is not required.
  - In_Valid with In_Ready=0 is ignored. The upstream holds the operand.
  - Out_Valid must not depend combinationally on Out_Ready.
- Boundary conditions:
  - Shift_Val=0 returns Shift_In unchanged in every mode.
  - Shift_Val=WIDTH-1 is the maximum; amounts are taken modulo WIDTH by construction.
  - Zero is valid only while Out_Valid=1.
  - Simultaneous out-transfer and in-transfer in the same cycle is legal: the pipeline advances by one.

Test Plan:
1. ROR, Shift_In=0x1234, Shift_Val=4, Out_Ready=1 -> after 4 cycles Out_Valid=1, Shift_Out=0x4123, Zero=0.
2. SRA 0x8000 by 15 -> 0xFFFF. SRL 0x8000 by 15 -> 0x0001. SLL 0x0001 by 15 -> 0x8000. SLL 0x8000 by 1 -> 0x0000 with Zero=1.
3. Back-to-back stream of 8 operands (mixed modes, amounts 0..7) with Out_Ready=1 -> 8 consecutive results on cycles 4..11, in order, each matching a software model. Shift_Val=0 entries equal their inputs.
4. Backpressure: fill the pipe, then drop Out_Ready for 5 cycles -> In_Ready=0 and Shift_Out/Zero/Out_Valid constant throughout. After Out_Ready=1, all results arrive in order with none lost or duplicated.
5. Reset mid-stream: 3 operands in flight, pulse rst_n low asynchronously between edges -> outputs clear immediately. After release, no stale Out_Valid ever appears, and a new operand completes with latency 4.
6. Random regression: 10k operands with random In_Valid/Out_Ready -> scoreboard matches the reference model across all four modes.
